turn_signal_input: RTL
======================

// Module: turn_signal_input
// PURPOSE
//   Input-conditioning stage directly upstream of the tail-light sequencer FSM.
//   - Synchronises and debounces the raw left/right switches.
//   - Arbitrates them into one mode: idle, left, right or hazard.
//   - Issues a one-cycle step enable (tick) that paces the sequencer.
//   - Replaces the divided clock: everything runs on the single system clock.
// PARAMETERS
//   DB_CYCLES    1_000_000   consecutive stable samples to accept a switch change (10 ms @ 100 MHz)
//   TICK_CYCLES  25_000_000  system-clock cycles per step tick (4 Hz @ 100 MHz); must be >= 2
// PORTS
//   clk_sys      in   1  system clock; all logic on rising edge
//   reset        in   1  synchronous, active-high reset
//   left_raw     in   1  asynchronous, bouncing left switch
//   right_raw    in   1  asynchronous, bouncing right switch
//   left_req     out  1  registered; sequencer runs left lamps (mode LEFT or HAZARD)
//   right_req    out  1  registered; sequencer runs right lamps (mode RIGHT or HAZARD)
//   hazard       out  1  registered; mode == HAZARD
//   tick         out  1  registered; 1-cycle step-enable pulse for the sequencer
// BEHAVIOUR
//   Reset
//   - Single clock domain; reset is synchronous and active-high.
//   - While reset is sampled high: sync flops, debounce counters, stable values,
//     tick counter and mode all go to 0 / IDLE.
//   - All outputs are 0 one edge after reset is sampled. Asserting reset
//     mid-operation aborts the current mode immediately.
//   Synchroniser
//   - Two flops per raw input. The second stage is the sample used by the debouncer.
//   Debounce (per channel)
//   - sync == stable: counter is cleared to 0.
//   - sync != stable: counter increments each cycle.
//   - When the counter reaches DB_CYCLES-1 while still differing: stable <= sync
//     and counter <= 0. A stable change therefore requires DB_CYCLES consecutive
//     differing samples.
//   - Any sample equal to stable restarts the count.
//   - Counter width is $clog2(DB_CYCLES)+1. The counter never wraps.
//   - Latency from raw edge to stable change: 2 + DB_CYCLES cycles.
//   Tick generator
//   - Free-running counter 0..TICK_CYCLES-1 that wraps to 0.
//   - tick = 1 in the cycle after the counter equals TICK_CYCLES-1, otherwise 0.
//   - First tick after reset release is at cycle TICK_CYCLES. Period is exactly
//     TICK_CYCLES.
//   Mode FSM
//   - States: IDLE, LEFT, RIGHT, HAZARD. Evaluated only on the cycle the tick
//     counter equals TICK_CYCLES-1, so a mode change and its tick are asserted
//     together.
//   - Both stable              -> HAZARD (from any state).
//   - Left only:  from IDLE/LEFT/HAZARD -> LEFT;  from RIGHT -> IDLE (lockout).
//   - Right only: from IDLE/RIGHT/HAZARD -> RIGHT; from LEFT -> IDLE (lockout).
//   - Neither                  -> IDLE.
//   - Lockout gives one full tick period with all lamps off before a direct
//     left<->right reversal. The next tick then enters the new direction if the
//     request persists.
//   - Between evaluation points the mode holds regardless of input changes.
//   Outputs
//   - left_req, right_req and hazard are decoded from the mode register and
//     registered. They change only on the same edge that tick rises.
// STRUCTURE
//   - Package turn_signal_pkg: 2-bit mode encoding constants
//     (MODE_IDLE=2'b00, MODE_LEFT=2'b01, MODE_RIGHT=2'b10, MODE_HAZARD=2'b11).
//   - Sub-module debouncer #(DB_CYCLES) (clk_sys, reset, raw, stable) contains
//     the 2-flop sync plus counter. It is instantiated twice.
//   - Tick generator and mode FSM live in the top module.
// TESTING  (override DB_CYCLES=4, TICK_CYCLES=8; reset held 2 cycles, released at cycle 0)
//   1. Idle, no inputs -> tick high at cycles 8,16,24,... for exactly 1 cycle each;
//      all req outputs stay 0.
//   2. left_raw 0->1 at cycle 1, held -> left stable at cycle 7; left_req=1 and
//      tick=1 both rise at cycle 8; right_req=hazard=0.
//   3. left_raw pattern 1,1,1,0 repeating from cycle 1 -> stable never rises;
//      left_req stays 0 for 100 cycles.
//   4. Both raw held high from cycle 1 -> at cycle 8, hazard=left_req=right_req=1.
//      Drop right_raw -> at the next tick only left_req=1.
//   5. In LEFT, switch to right_raw only -> next tick: all req outputs 0 (lockout);
//      following tick: right_req=1.
//   6. In HAZARD, assert reset at cycle 20 for 1 cycle -> all outputs 0 at cycle 21;
//      next tick exactly 8 cycles after reset release.

Source files
------------

// File: rtl/turn_signal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : turn_signal_pkg
//  Description : Mode encoding and decode helper for the turn-signal input
//                conditioning stage.
//  Revision    : 1.0  initial release
// ============================================================================
package turn_signal_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_HAZARD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = MODE_IDLE,
        ST_LEFT   = MODE_LEFT,
        ST_RIGHT  = MODE_RIGHT,
        ST_HAZARD = MODE_HAZARD
    } mode_t;

    // Lamp request vector {left_req, right_req, hazard} for a given mode.
    function automatic logic [2:0] decode_mode(input mode_t mode);
        logic [2:0] req;
        req = 3'b000;
        case (mode)
            ST_LEFT:   req = 3'b100;
            ST_RIGHT:  req = 3'b010;
            ST_HAZARD: req = 3'b111;
            default:   req = 3'b000;
        endcase
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer
//  Description : Two-flop synchroniser followed by a consecutive-sample
//                debounce counter for one bouncing switch.
//  Revision    : 1.0  initial release
// ============================================================================
module debouncer #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int                  c_cnt_w    = $clog2(DB_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any sample matching the accepted level restarts the run.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/turn_signal_input.sv
`default_nettype none
// ============================================================================
//  Module      : turn_signal_input
//  Description : Debounces left/right switches, arbitrates them into a lamp
//                mode and paces the tail-light sequencer with a step tick.
//  Revision    : 1.0  initial release
// ============================================================================
module turn_signal_input
    import turn_signal_pkg::*;
#(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int TICK_CYCLES = 25_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic left_req,
    output logic right_req,
    output logic hazard,
    output logic tick
);

    localparam int                   c_tick_w    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_tick_w-1:0]  c_tick_last = c_tick_w'(TICK_CYCLES - 1);
    localparam logic [c_tick_w-1:0]  c_tick_one  = c_tick_w'(1);

    logic w_left_stable;
    logic w_right_stable;

    debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_left (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (left_raw),
        .stable  (w_left_stable)
    );

    debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_right (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (right_raw),
        .stable  (w_right_stable)
    );

    // ------------------------------------------------------------------
    // Step tick: free-running 0..TICK_CYCLES-1, pulse follows the last count
    // ------------------------------------------------------------------
    logic [c_tick_w-1:0] r_tick_cnt;
    logic                r_tick;
    logic                w_eval;

    assign w_eval = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick_cnt <= w_eval ? '0 : (r_tick_cnt + c_tick_one);
            r_tick     <= w_eval;
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM, stepped only at the tick evaluation point
    // ------------------------------------------------------------------
    mode_t      r_mode;
    mode_t      w_mode_next;
    logic [2:0] r_req;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_mode <= ST_IDLE;
            r_req  <= 3'b000;
        end else begin
            r_mode <= w_mode_next;
            // Decoding the next mode lets the lamp requests rise with the tick.
            r_req  <= decode_mode(w_mode_next);
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (w_eval) begin
            case ({w_left_stable, w_right_stable})
                2'b11:   w_mode_next = ST_HAZARD;
                // A direct reversal passes through one dark tick period.
                2'b10:   w_mode_next = (r_mode == ST_RIGHT) ? ST_IDLE : ST_LEFT;
                2'b01:   w_mode_next = (r_mode == ST_LEFT)  ? ST_IDLE : ST_RIGHT;
                default: w_mode_next = ST_IDLE;
            endcase
        end
    end

    assign left_req  = r_req[2];
    assign right_req = r_req[1];
    assign hazard    = r_req[0];
    assign tick      = r_tick;

endmodule
`default_nettype wire
